// File: rtl/mem_host_loader.sv
// mem_host_loader: host-side sequencer for the CPU's external memory ports.
// A run loads a program from a valid/ready word stream into instruction memory,
// holds cpu_enable for a programmed number of cycles, then streams data memory
// back out through a valid/ready output port. All outputs are registered.
module mem_host_loader #(
    parameter logic [63:0] IMEM_BASE = 64'h0,
    parameter logic [63:0] DMEM_BASE = 64'h0,
    parameter int          CNT_W     = 16,
    parameter int          READ_LAT  = 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             start,
    input  logic [CNT_W-1:0] load_count,
    input  logic [31:0]      run_cycles,
    input  logic [CNT_W-1:0] dump_count,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [63:0]      m_data,
    output logic [63:0]      addr_ext,
    output logic             wen_ext,
    output logic             ren_ext,
    output logic [31:0]      wdata_ext,
    output logic [63:0]      addr_ext_2,
    output logic             wen_ext_2,
    output logic             ren_ext_2,
    output logic [63:0]      wdata_ext_2,
    input  logic [63:0]      rdata_ext_2,
    output logic             cpu_enable,
    output logic             busy,
    output logic             done
);

    // Wait counter must reach READ_LAT; one spare bit keeps the compare clean.
    localparam int                WAIT_W    = $clog2(READ_LAT + 1) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_LAT);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_ZERO = WAIT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_RD_OUT  = 3'd5,
        ST_FIN     = 3'd6
    } state_t;

    state_t state;
    state_t state_next;

    // Latched run parameters
    logic [CNT_W-1:0]  load_cnt_r;
    logic [31:0]       run_cnt_r;
    logic [CNT_W-1:0]  dump_cnt_r;

    // Phase progress counters
    logic [CNT_W-1:0]  load_idx_r;
    logic [31:0]       run_idx_r;
    logic [CNT_W-1:0]  dump_idx_r;
    logic [WAIT_W-1:0] wait_cnt_r;

    // Registered outputs
    logic [63:0]       addr_ext_r;
    logic              wen_ext_r;
    logic [31:0]       wdata_ext_r;
    logic [63:0]       addr_ext_2_r;
    logic              ren_ext_2_r;
    logic [63:0]       m_data_r;
    logic              m_valid_r;
    logic              cpu_enable_r;
    logic              busy_r;
    logic              done_r;

    // Decoded events
    logic              start_s;
    logic              load_hs_s;
    logic              load_last_s;
    logic              run_last_s;
    logic              wait_last_s;
    logic              dump_hs_s;
    logic              dump_last_s;

    // Instruction word i lives at IMEM_BASE + 4*i (index zero-extended, mod 2^64).
    function automatic logic [63:0] imem_addr(input logic [CNT_W-1:0] idx);
        logic [63:0] ext;
        ext             = 64'h0;
        ext[CNT_W-1:0]  = idx;
        return IMEM_BASE + (ext << 6'd2);
    endfunction

    // Data word j lives at DMEM_BASE + 8*j (index zero-extended, mod 2^64).
    function automatic logic [63:0] dmem_addr(input logic [CNT_W-1:0] idx);
        logic [63:0] ext;
        ext             = 64'h0;
        ext[CNT_W-1:0]  = idx;
        return DMEM_BASE + (ext << 6'd3);
    endfunction

    // First phase to enter once loading is over; zero counts skip their phase.
    function automatic state_t after_load(input logic [31:0] run_n,
                                          input logic [CNT_W-1:0] dump_n);
        state_t nxt;
        if (run_n != 32'd0) begin
            nxt = ST_RUN;
        end else if (dump_n != CNT_ZERO) begin
            nxt = ST_RD_REQ;
        end else begin
            nxt = ST_FIN;
        end
        return nxt;
    endfunction

    // Event decode from current state and handshakes
    always_comb begin
        start_s     = (state == ST_IDLE) && start;
        load_hs_s   = (state == ST_LOAD) && s_valid;
        load_last_s = load_hs_s && ((load_idx_r + CNT_ONE) == load_cnt_r);
        run_last_s  = (run_idx_r == run_cnt_r);
        wait_last_s = (wait_cnt_r == WAIT_LAST);
        dump_hs_s   = (state == ST_RD_OUT) && m_valid_r && m_ready;
        dump_last_s = ((dump_idx_r + CNT_ONE) == dump_cnt_r);
    end

    // State register
    always_ff @(posedge clk) begin
        if (srst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start_s) begin
                    if (load_count != CNT_ZERO) begin
                        state_next = ST_LOAD;
                    end else begin
                        state_next = after_load(run_cycles, dump_count);
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (load_last_s) begin
                    state_next = after_load(run_cnt_r, dump_cnt_r);
                end else begin
                    state_next = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (run_last_s) begin
                    state_next = (dump_cnt_r != CNT_ZERO) ? ST_RD_REQ : ST_FIN;
                end else begin
                    state_next = ST_RUN;
                end
            end
            ST_RD_REQ: begin
                state_next = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (wait_last_s) begin
                    state_next = ST_RD_OUT;
                end else begin
                    state_next = ST_RD_WAIT;
                end
            end
            ST_RD_OUT: begin
                if (dump_hs_s) begin
                    state_next = dump_last_s ? ST_FIN : ST_RD_REQ;
                end else begin
                    state_next = ST_RD_OUT;
                end
            end
            ST_FIN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Latch the run parameters when a run is accepted; start while busy is ignored
    always_ff @(posedge clk) begin
        if (srst) begin
            load_cnt_r <= CNT_ZERO;
            run_cnt_r  <= 32'd0;
            dump_cnt_r <= CNT_ZERO;
        end else if (start_s) begin
            load_cnt_r <= load_count;
            run_cnt_r  <= run_cycles;
            dump_cnt_r <= dump_count;
        end else begin
            load_cnt_r <= load_cnt_r;
            run_cnt_r  <= run_cnt_r;
            dump_cnt_r <= dump_cnt_r;
        end
    end

    // Load path: each accepted word becomes a one-cycle imem write next cycle
    always_ff @(posedge clk) begin
        if (srst) begin
            load_idx_r  <= CNT_ZERO;
            wen_ext_r   <= 1'b0;
            addr_ext_r  <= 64'h0;
            wdata_ext_r <= 32'h0;
        end else begin
            wen_ext_r <= load_hs_s;
            if (start_s) begin
                load_idx_r <= CNT_ZERO;
            end else if (load_hs_s) begin
                load_idx_r  <= load_idx_r + CNT_ONE;
                addr_ext_r  <= imem_addr(load_idx_r);
                wdata_ext_r <= s_data;
            end else begin
                load_idx_r <= load_idx_r;
            end
        end
    end

    // Run path: enable lags the RUN state by one cycle so it never meets the last write
    always_ff @(posedge clk) begin
        if (srst) begin
            run_idx_r    <= 32'd0;
            cpu_enable_r <= 1'b0;
        end else begin
            cpu_enable_r <= (state == ST_RUN) && !run_last_s;
            if (start_s) begin
                run_idx_r <= 32'd0;
            end else if ((state == ST_RUN) && !run_last_s) begin
                run_idx_r <= run_idx_r + 32'd1;
            end else begin
                run_idx_r <= run_idx_r;
            end
        end
    end

    // Dump path: request, wait out the read latency, capture, hold until accepted
    always_ff @(posedge clk) begin
        if (srst) begin
            dump_idx_r   <= CNT_ZERO;
            wait_cnt_r   <= WAIT_ZERO;
            ren_ext_2_r  <= 1'b0;
            addr_ext_2_r <= 64'h0;
            m_data_r     <= 64'h0;
            m_valid_r    <= 1'b0;
        end else begin
            ren_ext_2_r <= (state == ST_RD_REQ);
            case (state)
                ST_IDLE: begin
                    if (start_s) begin
                        dump_idx_r <= CNT_ZERO;
                    end else begin
                        dump_idx_r <= dump_idx_r;
                    end
                end
                ST_RD_REQ: begin
                    addr_ext_2_r <= dmem_addr(dump_idx_r);
                    wait_cnt_r   <= WAIT_ZERO;
                end
                ST_RD_WAIT: begin
                    if (wait_last_s) begin
                        m_data_r  <= rdata_ext_2;
                        m_valid_r <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_ONE;
                    end
                end
                ST_RD_OUT: begin
                    if (dump_hs_s) begin
                        m_valid_r  <= 1'b0;
                        dump_idx_r <= dump_idx_r + CNT_ONE;
                    end else begin
                        m_valid_r <= m_valid_r;
                    end
                end
                default: begin
                    m_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Run status: busy from the cycle after start, done pulses as busy drops
    always_ff @(posedge clk) begin
        if (srst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next != ST_IDLE);
            done_r <= (state == ST_FIN);
        end
    end

    assign s_ready     = (state == ST_LOAD);
    assign m_valid     = m_valid_r;
    assign m_data      = m_data_r;
    assign addr_ext    = addr_ext_r;
    assign wen_ext     = wen_ext_r;
    assign ren_ext     = 1'b0;
    assign wdata_ext   = wdata_ext_r;
    assign addr_ext_2  = addr_ext_2_r;
    assign wen_ext_2   = 1'b0;
    assign ren_ext_2   = ren_ext_2_r;
    assign wdata_ext_2 = 64'h0;
    assign cpu_enable  = cpu_enable_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: tb/tb_mem_host_loader.sv
// Bench for mem_host_loader: stream source, stalling sink and data memory models
// feed the DUT; a monitor logs port activity and each run is compared with the
// expected write/enable/read/output sequence derived from the run parameters.
module tb_mem_host_loader;

    localparam logic [63:0] IMEM_BASE = 64'h0000_0000_0000_1000;
    localparam logic [63:0] DMEM_BASE = 64'hFFFF_FFFF_FFFF_FFF0;
    localparam int          CNT_W     = 16;
    localparam int          READ_LAT  = 1;

    logic             clk = 1'b0;
    logic             srst;
    logic             start;
    logic [CNT_W-1:0] load_count;
    logic [31:0]      run_cycles;
    logic [CNT_W-1:0] dump_count;
    logic             s_valid;
    logic             s_ready;
    logic [31:0]      s_data;
    logic             m_valid;
    logic             m_ready;
    logic [63:0]      m_data;
    logic [63:0]      addr_ext;
    logic             wen_ext;
    logic             ren_ext;
    logic [31:0]      wdata_ext;
    logic [63:0]      addr_ext_2;
    logic             wen_ext_2;
    logic             ren_ext_2;
    logic [63:0]      wdata_ext_2;
    logic [63:0]      rdata_ext_2;
    logic             cpu_enable;
    logic             busy;
    logic             done;

    mem_host_loader #(
        .IMEM_BASE (IMEM_BASE),
        .DMEM_BASE (DMEM_BASE),
        .CNT_W     (CNT_W),
        .READ_LAT  (READ_LAT)
    ) dut (
        .clk         (clk),
        .srst        (srst),
        .start       (start),
        .load_count  (load_count),
        .run_cycles  (run_cycles),
        .dump_count  (dump_count),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .addr_ext    (addr_ext),
        .wen_ext     (wen_ext),
        .ren_ext     (ren_ext),
        .wdata_ext   (wdata_ext),
        .addr_ext_2  (addr_ext_2),
        .wen_ext_2   (wen_ext_2),
        .ren_ext_2   (ren_ext_2),
        .wdata_ext_2 (wdata_ext_2),
        .rdata_ext_2 (rdata_ext_2),
        .cpu_enable  (cpu_enable),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Stimulus configuration (written by the main sequence only)
    logic [31:0] src_words[$];
    int          src_mode = 0;
    int          src_gen = 0;
    int          sink_stall = 0;
    bit          sink_rand = 1'b0;
    int          sink_gen = 0;
    logic [63:0] dmem [16];

    // Written by the source only
    int          src_ptr;

    // Monitor logs (written by the monitor only)
    logic [63:0] wen_addr_q[$];
    logic [31:0] wen_data_q[$];
    int          wen_cyc_q[$];
    int          en_cyc_q[$];
    logic [63:0] ren_q[$];
    logic [63:0] out_q[$];
    int          done_cnt, inv_bad, stall_bad, stall_seen, done_busy_bad, cyc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Instruction stream source: advances on each accepted word
    initial begin : source
        int seen;
        bit hs;
        bit tog;
        bit want;
        s_valid = 1'b0;
        s_data  = 32'h0;
        src_ptr = 0;
        seen    = 0;
        tog     = 1'b0;
        forever begin
            @(negedge clk);
            hs = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (src_gen != seen) begin
                seen    = src_gen;
                src_ptr = 0;
                tog     = 1'b0;
            end else if (hs) begin
                src_ptr++;
            end
            case (src_mode)
                0:       want = 1'b1;
                1:       want = !tog;
                default: want = 1'($urandom_range(0, 1));
            endcase
            tog     = !tog;
            s_valid = want && (src_ptr < src_words.size());
            s_data  = (src_ptr < src_words.size()) ? src_words[src_ptr] : $urandom();
        end
    end

    // Output sink: holds m_ready low for sink_stall valid cycles, then accepts
    initial begin : sink
        int seen;
        int left;
        m_ready = 1'b0;
        seen    = 0;
        left    = 0;
        forever begin
            @(posedge clk);
            #1;
            if (sink_gen != seen) begin
                seen = sink_gen;
                left = sink_stall;
            end
            if (left > 0) begin
                m_ready = 1'b0;
                if (m_valid) left--;
            end else if (sink_rand) begin
                m_ready = 1'($urandom_range(0, 1));
            end else begin
                m_ready = 1'b1;
            end
        end
    end

    // Data memory: read data valid for exactly one cycle, READ_LAT=1 after ren
    initial begin : mem_model
        bit          p;
        logic [63:0] a;
        rdata_ext_2 = 64'h0;
        forever begin
            @(negedge clk);
            p = ren_ext_2;
            a = addr_ext_2;
            @(posedge clk);
            #1;
            if (p) rdata_ext_2 = dmem[a[6:3]];
            else   rdata_ext_2 = {$urandom(), $urandom()};
        end
    end

    // Monitor: logs port activity and counts invariant breaches
    initial begin : monitor
        bit          prev_stall;
        logic [63:0] prev_data;
        cyc = 0; done_cnt = 0; inv_bad = 0; stall_bad = 0; stall_seen = 0; done_busy_bad = 0;
        prev_stall = 1'b0;
        prev_data  = 64'h0;
        forever begin
            @(negedge clk);
            cyc++;
            if (wen_ext === 1'b1) begin
                wen_addr_q.push_back(addr_ext);
                wen_data_q.push_back(wdata_ext);
                wen_cyc_q.push_back(cyc);
            end
            if (cpu_enable === 1'b1) en_cyc_q.push_back(cyc);
            if (ren_ext_2 === 1'b1) ren_q.push_back(addr_ext_2);
            if (m_valid === 1'b1 && m_ready === 1'b1) out_q.push_back(m_data);
            if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data)) stall_bad++;
            if (m_valid === 1'b1 && m_ready === 1'b0) stall_seen++;
            if (m_valid === 1'b1 && ren_ext_2 === 1'b1) inv_bad++;
            prev_stall = (m_valid === 1'b1) && (m_ready === 1'b0) && (srst === 1'b0);
            prev_data  = m_data;
            if ((32'(wen_ext) + 32'(ren_ext_2) + 32'(cpu_enable)) > 32'd1) inv_bad++;
            if (wen_ext_2 !== 1'b0 || ren_ext !== 1'b0 || wdata_ext_2 !== 64'h0) inv_bad++;
            if (done === 1'b1) begin
                done_cnt++;
                if (busy !== 1'b0) done_busy_bad++;
            end
        end
    end

    // Run-length safety net
    initial begin : watchdog
        #600000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic fill_random(input int n);
        src_words = {};
        for (int i = 0; i < n + 2; i++) src_words.push_back($urandom());
        for (int i = 0; i < 16; i++) dmem[i] = {$urandom(), $urandom()};
    endtask

    task automatic pulse_start(input int l, input int r, input int d);
        @(posedge clk);
        #1;
        load_count = CNT_W'(l);
        run_cycles = 32'(r);
        dump_count = CNT_W'(d);
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_case(input string name, input int l, input int r, input int d,
                            input int vmode, input int stall, input bit rnd_sink, input bit poke);
        int          wb, eb, rb, ob, db;
        bit          seen;
        logic [63:0] a;
        src_mode   = vmode;
        src_gen++;
        sink_stall = stall;
        sink_rand  = rnd_sink;
        sink_gen++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        wb = wen_addr_q.size(); eb = en_cyc_q.size(); rb = ren_q.size();
        ob = out_q.size();      db = done_cnt;
        pulse_start(l, r, d);
        if (poke) begin
            seen = 1'b0;
            for (int i = 0; i < 200 && !seen; i++) begin
                @(negedge clk);
                if (cpu_enable === 1'b1) seen = 1'b1;
            end
            chk({name, ":reached_run"}, 64'(seen), 64'd1);
            pulse_start(9, 3, 3);
        end
        seen = 1'b0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        chk({name, ":done_seen"}, 64'(seen), 64'd1);
        repeat (8) @(negedge clk);
        #1;
        chk({name, ":wen_count"}, 64'(wen_addr_q.size() - wb), 64'(l));
        for (int i = 0; i < l && (wb + i) < wen_addr_q.size(); i++) begin
            chk({name, ":wen_addr"}, wen_addr_q[wb + i], IMEM_BASE + 64'(4 * i));
            chk({name, ":wen_data"}, 64'(wen_data_q[wb + i]), 64'(src_words[i]));
        end
        if (vmode == 0 && l > 0 && wen_cyc_q.size() > wb)
            chk({name, ":wen_back_to_back"}, 64'(wen_cyc_q[$] - wen_cyc_q[wb]), 64'(l - 1));
        chk({name, ":words_taken"}, 64'(src_ptr), 64'(l));
        chk({name, ":en_count"}, 64'(en_cyc_q.size() - eb), 64'(r));
        if (r > 0 && en_cyc_q.size() > eb)
            chk({name, ":en_contiguous"}, 64'(en_cyc_q[$] - en_cyc_q[eb]), 64'(r - 1));
        if (r > 0 && l > 0 && en_cyc_q.size() > eb && wen_cyc_q.size() > wb)
            chk({name, ":en_after_wen"}, 64'(en_cyc_q[eb] > wen_cyc_q[$]), 64'd1);
        chk({name, ":ren_count"}, 64'(ren_q.size() - rb), 64'(d));
        chk({name, ":out_count"}, 64'(out_q.size() - ob), 64'(d));
        for (int j = 0; j < d; j++) begin
            a = DMEM_BASE + 64'(8 * j);
            if ((rb + j) < ren_q.size()) chk({name, ":ren_addr"}, ren_q[rb + j], a);
            if ((ob + j) < out_q.size()) chk({name, ":out_data"}, out_q[ob + j], dmem[a[6:3]]);
        end
        chk({name, ":done_pulses"}, 64'(done_cnt - db), 64'd1);
        chk({name, ":busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin : main
        logic [63:0] ta;
        int          wb;
        bit          seen;
        srst = 1'b1; start = 1'b0;
        load_count = '0; run_cycles = 32'd0; dump_count = '0;
        for (int i = 0; i < 16; i++) dmem[i] = 64'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset:ctrl", {55'h0, s_ready, m_valid, wen_ext, ren_ext, wen_ext_2, ren_ext_2,
                           cpu_enable, busy, done}, 64'h0);
        chk("reset:addr_ext", addr_ext, 64'h0);
        chk("reset:addr_ext_2", addr_ext_2, 64'h0);
        chk("reset:wdata_ext", 64'(wdata_ext), 64'h0);
        chk("reset:m_data", m_data, 64'h0);
        @(posedge clk);
        #1;
        srst = 1'b0;

        // All counts zero: done two cycles after start
        @(posedge clk);
        #1;
        load_count = '0; run_cycles = 32'd0; dump_count = '0; start = 1'b1;
        @(negedge clk);
        chk("zero:busy_c0", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("zero:busy_c1", 64'(busy), 64'd1);
        chk("zero:done_c1", 64'(done), 64'd0);
        @(negedge clk);
        chk("zero:done_c2", 64'(done), 64'd1);
        chk("zero:busy_c2", 64'(busy), 64'd0);
        @(negedge clk);
        chk("zero:done_c3", 64'(done), 64'd0);

        // T1: three fixed words, valid held
        fill_random(3);
        src_words = {32'h00500093, 32'h00A00113, 32'h002081B3};
        run_case("t1", 3, 0, 0, 0, 0, 1'b0, 1'b0);
        // T2: toggling valid, extra words offered
        fill_random(4);
        run_case("t2", 4, 0, 0, 1, 0, 1'b0, 1'b0);
        // T3: run phase only
        fill_random(0);
        run_case("t3", 0, 10, 0, 0, 0, 1'b0, 1'b0);
        // T4: dump two words with a 5-cycle sink stall
        fill_random(0);
        ta = DMEM_BASE;          dmem[ta[6:3]] = 64'hDEAD;
        ta = DMEM_BASE + 64'd8;  dmem[ta[6:3]] = 64'hBEEF;
        run_case("t4", 0, 0, 2, 0, 5, 1'b0, 1'b0);
        // T5: start pulsed during RUN is ignored
        fill_random(2);
        run_case("t5", 2, 20, 1, 0, 0, 1'b0, 1'b1);

        // T6: reset during LOAD after two words, then restart
        fill_random(5);
        src_mode = 0;
        src_gen++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        wb = wen_addr_q.size();
        pulse_start(5, 0, 0);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (wen_addr_q.size() >= wb + 2) seen = 1'b1;
        end
        chk("t6:two_words", 64'(seen), 64'd1);
        @(posedge clk);
        #1;
        srst = 1'b1;
        @(posedge clk);
        #1;
        srst = 1'b0;
        @(negedge clk);
        chk("t6:ctrl", {56'h0, s_ready, m_valid, wen_ext, ren_ext_2, cpu_enable, busy, done, 1'b0},
            64'h0);
        chk("t6:addr_ext", addr_ext, 64'h0);
        chk("t6:wdata_ext", 64'(wdata_ext), 64'h0);
        fill_random(3);
        run_case("t6r", 3, 2, 1, 0, 0, 1'b0, 1'b0);

        // Randomized runs, wrapping dump addresses included
        for (int k = 0; k < 6; k++) begin
            int l, r, d;
            l = int'($urandom_range(0, 6));
            r = int'($urandom_range(0, 8));
            d = int'($urandom_range(0, 4));
            fill_random(l);
            run_case("rand", l, r, d, 2, int'($urandom_range(0, 3)), 1'b1, 1'b0);
        end

        chk("global:invariants", 64'(inv_bad), 64'd0);
        chk("global:m_data_held", 64'(stall_bad), 64'd0);
        chk("global:stall_exercised", 64'(stall_seen > 0), 64'd1);
        chk("global:done_with_busy", 64'(done_busy_bad), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
